decoder_rr_arbiter: RTL

Four-requester round-robin arbiter that owns the 2-bit select of the active-high 2-to-4 decoder. It arbitrates request lines and drives the registered select pair `sel[1:0]` onto the decoder's `s1`/`s0` inputs, so exactly one decoder output is high per granted cycle. It also produces a qualified one-hot grant vector for requesters, and an optional hold limit preempts an owner that monopolises the decoder.

---
 rtl/decoder_rr_arbiter_if.sv | 22 ++
 rtl/decoder_rr_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the round-robin arbiter and its four requesters.
// The arbiter owns the master side; requesters (or a bench) use the slave side.
interface decoder_rr_arbiter_if;
  // Handshake: req[i] is a level request and stays high for the whole transfer.
  // grant[i] is valid only while gnt_valid=1. Lowering req[sel] releases the decoder.
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       gnt_valid;
  logic       forced;
  logic       state_dbg;

  modport master (
    input  req,
    output sel, grant, gnt_valid, forced, state_dbg
  );

  modport slave (
    output req,
    input  sel, grant, gnt_valid, forced, state_dbg
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Four-requester round-robin arbiter driving the 2-to-4 decoder select pair.
// Optional owner hold limit with forced rotation: define ARB_HOLD_LIMIT_EN.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decoder_rr_arbiter_if.master  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_inc;
  logic [3:0] others;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_SAT = HW'(MAX_HOLD - 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          forced_q, forced_d;
`endif

  // First set bit of r, searching start, start+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign sel_inc = sel_q + 2'd1;
  assign others  = bus.req & ~(4'b0001 << sel_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d   = hold_q;
    forced_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          sel_d   = rr_pick(bus.req, ptr_q);
          state_d = GRANT;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          // Release: hand over without a bubble if anyone else is waiting.
          ptr_d = sel_inc;
          if (|others) begin
            sel_d  = rr_pick(others, sel_inc);
`ifdef ARB_HOLD_LIMIT_EN
            hold_d = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (hold_q == HOLD_SAT && |others) begin
          sel_d    = rr_pick(others, sel_inc);
          ptr_d    = sel_inc;
          hold_d   = '0;
          forced_d = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      forced_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      forced_q <= forced_d;
    end
  end
  assign bus.forced = forced_q;
`else
  assign bus.forced = 1'b0;
`endif

  // grant is a single AND level off registered state; no path from req.
  assign bus.sel       = sel_q;
  assign bus.gnt_valid = (state_q == GRANT);
  assign bus.grant     = {4{state_q == GRANT}} & (4'b0001 << sel_q);
  assign bus.state_dbg = state_q;

endmodule
